// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: widths, memory depth, port ids and request record shared by the data-memory arbiter
package dmem_arb_pkg;
   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 16;
   localparam int DEPTH    = 64;
   localparam int MAX_WAIT = 4;
   typedef enum logic {PORT_CPU = 1'b0, PORT_DBG = 1'b1} port_t;
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way grant pick from request vector, last winner and a debug override
module dmem_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      lastWin,
   input  logic       forceDbg,
   output logic [1:0] gnt
);
   logic cpuWin;
   // CPU yields under contention when debug is forced or CPU won last; debug takes what CPU leaves
   always_comb begin
      cpuWin = req[0] & ~(req[1] & (forceDbg | (lastWin == PORT_CPU)));
      gnt    = {req[1] & ~cpuWin, cpuWin};
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 64x16 data memory port between CPU (port 0) and debug loader (port 1)
// Optional: DMEM_ARB_CPU_PRIO_EN gives the CPU fixed priority with a debug starvation limit.
module dmem_arbiter
   import dmem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   req_t              cpuReq, dbgReq, selReq;
   logic [1:0]        reqV, gnt;
   logic              anyGnt, oor, isRead;
   logic [DATA_W-1:0] rdNext;

   assign cpuReq = '{cpu_we, cpu_addr, cpu_wdata};
   assign dbgReq = '{dbg_we, dbg_addr, dbg_wdata};
   // requests seen during reset must not produce a grant
   assign reqV   = {dbg_req, cpu_req} & {2{reset_n}};

`ifdef DMEM_ARB_CPU_PRIO_EN
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
   logic [CW-1:0] waitCnt;
   logic          forceDbg;
   assign forceDbg = (waitCnt == WAIT_LIM);
   // count cycles debug waits ungranted; a debug grant or a dropped request clears it
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) waitCnt <= '0;
      else if (!dbg_req || gnt[1]) waitCnt <= '0;
      else if (!forceDbg) waitCnt <= waitCnt + 1'b1;
   dmem_rr_pick uPick (.req(reqV), .lastWin(PORT_DBG), .forceDbg(forceDbg), .gnt(gnt));
`else
   port_t lastWin;
   // round-robin pointer follows the latest winner; idle cycles leave it alone
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) lastWin <= PORT_CPU;
      else if (gnt[1]) lastWin <= PORT_DBG;
      else if (gnt[0]) lastWin <= PORT_CPU;
   dmem_rr_pick uPick (.req(reqV), .lastWin(lastWin), .forceDbg(1'b0), .gnt(gnt));
`endif

   assign selReq  = gnt[1] ? dbgReq : cpuReq;
   assign anyGnt  = |gnt;
   assign oor     = selReq.addr >= ADDR_W'(DEPTH);
   assign isRead  = ~selReq.we;
   assign rdNext  = oor ? '0 : mem_rdata;
   assign cpu_gnt = gnt[0];
   assign dbg_gnt = gnt[1];

   // drive the memory only for a granted in-range access; idle bus is all zero
   always_comb begin
      mem_we    = anyGnt & selReq.we & ~oor;
      mem_re    = anyGnt & isRead & ~oor;
      mem_addr  = anyGnt ? selReq.addr : '0;
      mem_wdata = anyGnt ? selReq.wdata : '0;
   end

   // one-cycle response pipeline; read data holds until the port's next read response
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cpu_rvalid <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rvalid <= 1'b0;
         dbg_err    <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         cpu_rvalid <= gnt[0] & isRead;
         cpu_err    <= gnt[0] & oor;
         dbg_rvalid <= gnt[1] & isRead;
         dbg_err    <= gnt[1] & oor;
         if (gnt[0] & isRead) cpu_rdata <= rdNext;
         if (gnt[1] & isRead) dbg_rdata <= rdNext;
      end
endmodule
